// File: rtl/calc_pkg.sv
// calc_pkg: key codes, state and pending-op encodings shared by the calculator sequencer.
package calc_pkg;
    localparam logic [3:0] KEY_ADD   = 4'd10;
    localparam logic [3:0] KEY_SUB   = 4'd11;
    localparam logic [3:0] KEY_STORE = 4'd12;
    localparam logic [3:0] KEY_LOAD  = 4'd13;
    localparam logic [3:0] KEY_ENTER = 4'd14;
    localparam logic [3:0] KEY_CLEAR = 4'd15;
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ST_ADDR, S_LD_ADDR, S_LD_WAIT} state_t;
    typedef enum logic [1:0] {P_NONE, P_ADD, P_SUB} pend_t;
    typedef enum logic {N_OP, N_ENTER} next_t;
    function automatic logic is_digit(input logic [3:0] k);
        return k < 4'd10;
    endfunction
endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: key handshake, adder, register-file and display signals of the sequencer.
interface calc_sequencer_if #(parameter int W = 8, parameter int AW = 4);
    logic          key_valid;
    logic [3:0]    key_code;
    logic          key_ready;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          alu_sub;
    logic [W-1:0]  alu_result;
    logic          alu_cout;
    logic [AW-1:0] rf_addr;
    logic          rf_we;
    logic [W-1:0]  rf_wdata;
    logic [W-1:0]  rf_rdata;
    logic [W-1:0]  display;
    logic          err;
    modport master (
        input  key_valid, key_code, alu_result, alu_cout, rf_rdata,
        output key_ready, alu_a, alu_b, alu_sub, rf_addr, rf_we, rf_wdata, display, err
    );
    modport slave (
        output key_valid, key_code, alu_result, alu_cout, rf_rdata,
        input  key_ready, alu_a, alu_b, alu_sub, rf_addr, rf_we, rf_wdata, display, err
    );
endinterface

// File: rtl/calc_sequencer_digit_accum.sv
// calc_digit_accum: decimal entry step val*10+d with overflow flag when the true value exceeds W bits.
module calc_digit_accum #(parameter int W = 8) (
    input  logic [W-1:0] val,
    input  logic [3:0]   d,
    output logic [W-1:0] nxt,
    output logic         ovf
);
    logic [W+3:0] wide;
    assign wide = {4'b0, val} * (W+4)'(10) + (W+4)'(d);
    assign nxt  = wide[W-1:0];
    assign ovf  = |wide[W+3:W];
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad sequencing controller driving the shared adder, register file and display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W    = 8,
    parameter int AW   = 4,
    parameter int NREG = 10
) (
    input logic clk,
    input logic reset,
    calc_sequencer_if.master bus
);
    localparam logic [3:0] NR = 4'(NREG);
    state_t state, state_n;
    pend_t pend, op_lat, op_code;
    next_t nxt;
    logic [W-1:0] ent, acc, ent_nx;
    logic [AW-1:0] addr_q;
    logic disp_sel, err_q, ovf, rdy, acc_key, digit, addr_ok, is_op, is_ent, clr;
    logic [3:0] k;
    assign k       = bus.key_code;
    assign rdy     = state == S_IDLE || state == S_ST_ADDR || state == S_LD_ADDR;
    assign acc_key = bus.key_valid && rdy;
    assign digit   = is_digit(k);
    assign addr_ok = digit && k < NR;
    assign is_op   = k == KEY_ADD || k == KEY_SUB;
    assign is_ent  = k == KEY_ENTER;
    assign clr     = acc_key && k == KEY_CLEAR;
    assign op_code = k == KEY_SUB ? P_SUB : P_ADD;

    calc_digit_accum #(.W(W)) u_accum (.val(ent), .d(k), .nxt(ent_nx), .ovf(ovf));

    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_n;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (acc_key) state_n = (is_op || is_ent) && pend != P_NONE ? S_EXEC :
                                              k == KEY_STORE ? S_ST_ADDR :
                                              k == KEY_LOAD  ? S_LD_ADDR : S_IDLE;
            S_ST_ADDR: if (acc_key) state_n = S_IDLE;
            S_LD_ADDR: if (acc_key) state_n = addr_ok ? S_LD_WAIT : S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bus.key_ready = rdy;
        bus.alu_a     = acc;
        bus.alu_b     = ent;
        bus.alu_sub   = state == S_EXEC && pend == P_SUB;
        bus.rf_we     = state == S_ST_ADDR && acc_key && addr_ok;
        // the read address goes out with the LOAD digit so data arrives during S_LD_WAIT
        bus.rf_addr   = (state == S_ST_ADDR || state == S_LD_ADDR) && acc_key && addr_ok ? AW'(k) : addr_q;
        bus.rf_wdata  = acc;
        bus.display   = disp_sel ? acc : ent;
        bus.err       = err_q;
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ent      <= '0;
            acc      <= '0;
            pend     <= P_NONE;
            op_lat   <= P_NONE;
            nxt      <= N_OP;
            disp_sel <= 1'b0;
            err_q    <= 1'b0;
            if (reset) addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (acc_key) begin
                    if (digit) begin
                        ent      <= ent_nx;
                        err_q    <= err_q | ovf;
                        disp_sel <= 1'b0;
                    end else if ((is_op || is_ent) && pend == P_NONE) begin
                        acc      <= ent;
                        ent      <= '0;
                        disp_sel <= 1'b1;
                        if (is_op) pend <= op_code;
                    end else if (is_op || is_ent) begin
                        nxt <= is_op ? N_OP : N_ENTER;
                        if (is_op) op_lat <= op_code;
                    end
                end
                S_EXEC: begin
                    acc      <= bus.alu_result;
                    ent      <= '0;
                    disp_sel <= 1'b1;
                    err_q    <= err_q | (pend == P_SUB ? ~bus.alu_cout : bus.alu_cout);
                    pend     <= nxt == N_OP ? op_lat : P_NONE;
                end
                S_ST_ADDR: if (acc_key && digit && !addr_ok) err_q <= 1'b1;
                S_LD_ADDR: if (acc_key) begin
                    if (digit && !addr_ok) err_q <= 1'b1;
                    if (addr_ok) addr_q <= AW'(k);
                end
                S_LD_WAIT: begin
                    ent      <= bus.rf_rdata;
                    disp_sel <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
